// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU board I/O stage:
// debounce FSM states, display-select encodings and 7-segment hex codes.
package cpu_io_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StPressed,
        StWaitRelease
    } dbnc_state_e;

    localparam logic [1:0] SEL_PC  = 2'd0;
    localparam logic [1:0] SEL_RS  = 2'd1;
    localparam logic [1:0] SEL_RT  = 2'd2;
    localparam logic [1:0] SEL_ALU = 2'd3;

    // Active-low gfedcba segment codes.
    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_RESET  = 4'b1110;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] code;
        code = HEX_0;
        unique case (nib)
            4'h0: code = HEX_0;
            4'h1: code = HEX_1;
            4'h2: code = HEX_2;
            4'h3: code = HEX_3;
            4'h4: code = HEX_4;
            4'h5: code = HEX_5;
            4'h6: code = HEX_6;
            4'h7: code = HEX_7;
            4'h8: code = HEX_8;
            4'h9: code = HEX_9;
            4'hA: code = HEX_A;
            4'hB: code = HEX_B;
            4'hC: code = HEX_C;
            4'hD: code = HEX_D;
            4'hE: code = HEX_E;
            4'hF: code = HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_step_display_if.sv
// CPU-observation buses, step button and display pins of the board I/O stage.
interface cpu_step_display_if;

    logic        btn_step;
    logic [1:0]  sw_sel;
    logic [31:0] curPC;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] ALUData;
    logic        cpu_step;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output btn_step, sw_sel, curPC, readData1, readData2, ALUData,
        input  cpu_step, an, seg
    );

    modport slave (
        input  btn_step, sw_sel, curPC, readData1, readData2, ALUData,
        output cpu_step, an, seg
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; emits a one-cycle
// pulse per accepted press.
module btn_debounce
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            btn_s_q;
    dbnc_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == StPressed);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (btn_s_q) begin
                    state_d = StWaitPress;
                    cnt_d   = '0;
                end
            end
            StWaitPress: begin
                if (!btn_s_q) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                state_d = StWaitRelease;
                cnt_d   = '0;
            end
            StWaitRelease: begin
                // Any high sample restarts the release qualification.
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_step_display.sv
// Board I/O stage: debounced single-step pulse and a 4-digit multiplexed
// 7-segment view of the low half of a selected CPU bus.
module cpu_step_display
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input logic               CLK,
    input logic               Reset,
    cpu_step_display_if.slave io
);

    localparam int unsigned      ScanW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);

    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [31:0]      sel_word;
    logic [3:0]       nibble;
    logic             unused_sel_hi;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i  (CLK),
        .rst_i  (Reset),
        .btn_i  (io.btn_step),
        .pulse_o(io.cpu_step)
    );

    always_comb begin
        sel_word = io.curPC;
        unique case (io.sw_sel)
            SEL_PC:  sel_word = io.curPC;
            SEL_RS:  sel_word = io.readData1;
            SEL_RT:  sel_word = io.readData2;
            SEL_ALU: sel_word = io.ALUData;
        endcase
    end

    // Only the low 16 bits fit on four digits.
    assign unused_sel_hi = ^sel_word[31:16];

    always_comb begin
        nibble = sel_word[3:0];
        unique case (digit_q)
            2'd0: nibble = sel_word[3:0];
            2'd1: nibble = sel_word[7:4];
            2'd2: nibble = sel_word[11:8];
            2'd3: nibble = sel_word[15:12];
        endcase
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == ScanMax) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
        an_d  = ~(4'b0001 << digit_q);
        seg_d = {1'b1, hex_decode(nibble)};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            an_q       <= AN_RESET;
            seg_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign io.an  = an_q;
    assign io.seg = seg_q;

endmodule

// File: tb/tb_cpu_step_display.sv
// Directed bench for cpu_step_display with DEBOUNCE_CYCLES=4, SCAN_CYCLES=3.
module tb_cpu_step_display;

    typedef struct {
        logic [1:0]      sel;
        logic [3:0][6:0] code;  // expected 7-bit code per digit, [0] = rightmost
    } disp_vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_step_display_if dut_if ();

    cpu_step_display #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES    (3)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .io   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_an", {28'd0, dut_if.an}, 32'h0000000E);
            check("reset_seg", {24'd0, dut_if.seg}, 32'h000000FF);
            check("reset_step", {31'd0, dut_if.cpu_step}, 32'd0);
        end
        rst = 1'b0;
    endtask

    // Runs n cycles, returning pulse count and 1-based cycle of the first pulse.
    task automatic count_pulses(input int n, output int pulses, output int pos);
        pulses = 0;
        pos    = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (dut_if.cpu_step === 1'b1) begin
                pulses++;
                if (pos == 0) pos = i;
            end
        end
    endtask

    disp_vec_t  vecs [4];
    logic [3:0] an_tab [4];
    logic [3:0] an_hist [48];
    int         pulses;
    int         pos;
    int         dig;
    logic [1:0] bounce [4];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        dut_if.btn_step  = 1'b0;
        dut_if.sw_sel    = 2'd0;
        dut_if.curPC     = 32'h00401234;
        dut_if.readData1 = 32'hDEAD5678;
        dut_if.readData2 = 32'h1234EF09;
        dut_if.ALUData   = 32'h0000ABCD;

        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;

        vecs[0].sel = 2'd0; vecs[0].code = {7'h79, 7'h24, 7'h30, 7'h19};
        vecs[1].sel = 2'd1; vecs[1].code = {7'h12, 7'h02, 7'h78, 7'h00};
        vecs[2].sel = 2'd2; vecs[2].code = {7'h06, 7'h0E, 7'h40, 7'h10};
        vecs[3].sel = 2'd3; vecs[3].code = {7'h08, 7'h03, 7'h46, 7'h21};

        // Display: every bus selection across one full refresh period.
        for (int v = 0; v < 4; v++) begin
            dut_if.sw_sel = vecs[v].sel;
            do_reset();
            for (int k = 0; k < 12; k++) begin
                tick();
                dig = (k / 3) % 4;
                check("disp_an", {28'd0, dut_if.an}, {28'd0, an_tab[dig]});
                check("disp_seg", {24'd0, dut_if.seg}, {24'd0, 1'b1, vecs[v].code[dig]});
            end
        end

        // Select change mid-scan shows on the next refresh.
        dut_if.sw_sel = 2'd0;
        do_reset();
        for (int k = 0; k < 12; k++) tick();
        dut_if.sw_sel = 2'd3;
        for (int k = 12; k < 18; k++) begin
            tick();
            dig = (k / 3) % 4;
            check("swap_seg", {24'd0, dut_if.seg}, {24'd0, 1'b1, vecs[3].code[dig]});
        end
        dut_if.sw_sel = 2'd0;

        // Clean press held 20 cycles, then release and a second press.
        do_reset();
        dut_if.btn_step = 1'b1;
        count_pulses(20, pulses, pos);
        check("press1_count", pulses, 1);
        check("press1_latency", pos, 7);
        dut_if.btn_step = 1'b0;
        count_pulses(12, pulses, pos);
        check("release_count", pulses, 0);
        dut_if.btn_step = 1'b1;
        count_pulses(12, pulses, pos);
        check("press2_count", pulses, 1);
        check("press2_latency", pos, 7);
        dut_if.btn_step = 1'b0;
        count_pulses(12, pulses, pos);

        // Bounce shorter than the debounce window.
        bounce[0] = 2'd1; bounce[1] = 2'd0; bounce[2] = 2'd1; bounce[3] = 2'd0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            dut_if.btn_step = bounce[i][0];
            tick();
            if (dut_if.cpu_step === 1'b1) pulses++;
        end
        dut_if.btn_step = 1'b0;
        count_pulses(15, pos, dig);
        check("bounce_count", pulses + pos, 0);

        // Reset during WAIT_PRESS, button still held afterwards.
        do_reset();
        dut_if.btn_step = 1'b1;
        count_pulses(4, pulses, pos);
        check("pre_reset_count", pulses, 0);
        rst = 1'b1;
        tick();
        check("midreset_step", {31'd0, dut_if.cpu_step}, 32'd0);
        rst = 1'b0;
        count_pulses(16, pulses, pos);
        check("post_reset_count", pulses, 1);
        check("post_reset_latency", pos, 7);
        dut_if.btn_step = 1'b0;
        count_pulses(12, pulses, pos);

        // Reset while in PRESSED drops the pulse on that edge.
        do_reset();
        dut_if.btn_step = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("pressed_step", {31'd0, dut_if.cpu_step}, 32'd1);
        rst = 1'b1;
        tick();
        check("pressed_reset_step", {31'd0, dut_if.cpu_step}, 32'd0);
        rst = 1'b0;
        dut_if.btn_step = 1'b0;
        count_pulses(12, pulses, pos);

        // Scan wrap: one-hot-low anodes, period 12.
        do_reset();
        for (int k = 0; k < 48; k++) begin
            tick();
            an_hist[k] = dut_if.an;
            check("wrap_onehot", $countones(~an_hist[k]), 1);
            check("wrap_seq", {28'd0, an_hist[k]}, {28'd0, an_tab[(k / 3) % 4]});
            if (k >= 12) check("wrap_period", {28'd0, an_hist[k]}, {28'd0, an_hist[k - 12]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
